// File: rtl/pipe_elastic_stage.sv
// ---------------------------------------------------------------------------
// pipe_elastic_stage
//
// Elastic pipeline stage placed between two CPU datapath stages. A DEPTH-entry
// circular FIFO carries PC, IR and a packed control/data payload using a
// valid/ready handshake. It also reports occupancy and counts cycles where
// upstream was blocked.
//
// Parameters
//   PC_BITS    program-counter width
//   IR_BITS    instruction-register width
//   PAYLOAD_W  packed control plus data bits; the sender defines field order
//   DEPTH      number of entries; must be a power of two and at least 2
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all entries
//   in_valid     upstream presents an entry
//   in_ready     stage accepts an entry this cycle
//   in_pc        incoming PC
//   in_ir        incoming instruction word
//   in_payload   incoming control/data bundle
//   out_valid    head entry is valid
//   out_ready    downstream consumes the head this cycle
//   out_pc       head PC, zero when empty
//   out_ir       head instruction word, zero when empty
//   out_payload  head control/data bundle, zero when empty
//   occupancy    number of entries held (0..DEPTH)
//   stall_cnt    saturating count of cycles with in_valid & ~in_ready
// ---------------------------------------------------------------------------
module pipe_elastic_stage #(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int PAYLOAD_W = 160,
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_BITS-1:0]       in_pc,
    input  logic [IR_BITS-1:0]       in_ir,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_BITS-1:0]       out_pc,
    output logic [IR_BITS-1:0]       out_ir,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 ready_en;

    logic [PC_BITS-1:0]   mem_pc      [DEPTH];
    logic [IR_BITS-1:0]   mem_ir      [DEPTH];
    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];

    logic                 push;
    logic                 pop;
    logic                 stall;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // in_ready looks only at registered state, so no combinational path
    // exists from out_ready back to in_ready. A full stage therefore takes
    // one cycle after a pop before it accepts again.
    assign in_ready  = ready_en & (count != COUNT_FULL);
    assign out_valid = (count != '0);

    assign push  = in_valid  & in_ready  & ~flush;
    assign pop   = out_valid & out_ready & ~flush;
    assign stall = in_valid  & ~in_ready;

    // ------------------------------------------------------------------
    // Ready enable: holds in_ready low for the first edge after reset
    // release, so upstream never sees ready while reset is settling.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and count. DEPTH is a power of two, so the natural
    // overflow of the AW-bit pointers gives the DEPTH-1 -> 0 wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Contents are don't-care while not counted as valid,
    // so no reset is applied and flush leaves stale data behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]      <= in_pc;
            mem_ir[wr_ptr]      <= in_ir;
            mem_payload[wr_ptr] <= in_payload;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: saturates rather than wrapping; flush leaves it alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs, forced to a zero bubble when empty so stale storage
    // never leaks downstream.
    // ------------------------------------------------------------------
    always_comb begin
        out_pc      = '0;
        out_ir      = '0;
        out_payload = '0;
        if (out_valid) begin
            out_pc      = mem_pc[rd_ptr];
            out_ir      = mem_ir[rd_ptr];
            out_payload = mem_payload[rd_ptr];
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
module tb_pipe_elastic_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    // DEPTH = 2 instance
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_pc = '0;
    logic [31:0]  in_ir = '0;
    logic [159:0] in_payload = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_pc;
    logic [31:0]  out_ir;
    logic [159:0] out_payload;
    logic [1:0]   occupancy;
    logic [31:0]  stall_cnt;

    // DEPTH = 4 instance
    logic         flush4 = 1'b0;
    logic         in_valid4 = 1'b0;
    logic         in_ready4;
    logic [31:0]  in_pc4 = '0;
    logic [31:0]  in_ir4 = '0;
    logic [159:0] in_payload4 = '0;
    logic         out_valid4;
    logic         out_ready4 = 1'b0;
    logic [31:0]  out_pc4;
    logic [31:0]  out_ir4;
    logic [159:0] out_payload4;
    logic [2:0]   occupancy4;
    logic [31:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_elastic_stage #(.PC_BITS(32), .IR_BITS(32), .PAYLOAD_W(160), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_payload(out_payload),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_elastic_stage #(.PC_BITS(32), .IR_BITS(32), .PAYLOAD_W(160), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_pc(in_pc4), .in_ir(in_ir4), .in_payload(in_payload4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_pc(out_pc4), .out_ir(out_ir4), .out_payload(out_payload4),
        .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b occ=%0d stall=%0d want 0 0 0 0",
                     in_ready, out_valid, occupancy, stall_cnt);
        end
        checks++;
        if (out_pc !== 32'd0 || out_ir !== 32'd0 || out_payload !== 160'd0) begin
            errors++;
            $display("FAIL reset_outputs pc=%h ir=%h want zero", out_pc, out_ir);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_edge in_ready=%b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_first_edge in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0040_0000;
        pcs[1] = 32'h0040_0004;
        pcs[2] = 32'h0040_0008;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = pcs[i];
            in_ir    = 32'h1000_0000 + i;
            checks++;
            if (i == 0 && out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_no_bypass out_valid=%b want 0", out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream_out%0d valid=%b pc=%h occ=%0d want 1 %h 1",
                         i, out_valid, out_pc, occupancy, pcs[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain valid=%b pc=%h occ=%0d want 0 0 0", out_valid, out_pc, occupancy);
        end
    endtask

    task automatic test_fill_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = 32'h2008_0005;
        tick();
        in_ir     = 32'h2009_0007;
        tick();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full occ=%0d in_ready=%b want 2 0", occupancy, in_ready);
        end
        in_ir = 32'h200A_0009;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL fill_stall_cnt got %0d want 4", stall_cnt);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_ir !== 32'h2008_0005 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_head ir=%h in_ready=%b want 20080005 0", out_ir, in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_ir !== 32'h2009_0007 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL fill_after_pop in_ready=%b ir=%h occ=%0d want 1 20090007 1",
                     in_ready, out_ir, occupancy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_ir !== 32'h200A_0009 || occupancy !== 2'd1 || stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL fill_third ir=%h occ=%0d stall=%0d want 200a0009 1 5",
                     out_ir, occupancy, stall_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL fill_drain valid=%b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_simultaneous();
        logic [159:0] exp_pl;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = {5{32'hC0DE_0000}};
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            exp_pl     = {5{32'hC0DE_0000 + 32'(i - 1)}};
            in_payload = {5{32'hC0DE_0000 + 32'(i)}};
            checks++;
            if (out_payload !== exp_pl || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL simul_step%0d payload_lo=%h occ=%0d want %h 1",
                         i, out_payload[31:0], occupancy, exp_pl[31:0]);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_payload !== {5{32'hC0DE_000A}} || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL simul_last payload_lo=%h occ=%0d want c0de000a 1", out_payload[31:0], occupancy);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_pc    = 32'h0000_1000;
        tick();
        in_pc    = 32'h0000_1004;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre occ=%0d want 2", occupancy);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h0000_DEAD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 ||
            out_ir !== 32'd0 || out_payload !== 160'd0) begin
            errors++;
            $display("FAIL flush_clear occ=%0d valid=%b pc=%h want 0 0 0", occupancy, out_valid, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_push_dropped valid=%b occ=%0d pc=%h want 0 0", out_valid, occupancy, out_pc);
        end
        // Stage still works after flush.
        in_valid = 1'b1;
        in_pc    = 32'h0000_2000;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0000_2000) begin
            errors++;
            $display("FAIL flush_recover valid=%b pc=%h want 1 00002000", out_valid, out_pc);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_3000;
        tick();
        tick();
        tick();
        checks++;
        if (occupancy !== 2'd2 || stall_cnt === 32'd0) begin
            errors++;
            $display("FAIL areset_pre occ=%0d stall=%0d want 2 nonzero", occupancy, stall_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 32'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate valid=%b occ=%0d stall=%0d ready=%b want 0 0 0 0",
                     out_valid, occupancy, stall_cnt, in_ready);
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL areset_release ready=%b occ=%0d want 1 0", in_ready, occupancy);
        end
    endtask

    task automatic test_depth4();
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_pc4    = 32'h0050_0000 + 32'(4 * i);
            tick();
        end
        in_valid4 = 1'b0;
        checks++;
        if (occupancy4 !== 3'd4 || in_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL d4_full occ=%0d ready=%b want 4 0", occupancy4, in_ready4);
        end
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid4 !== 1'b1 || out_pc4 !== 32'h0050_0000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL d4_drain%0d valid=%b pc=%h want 1 %h",
                         i, out_valid4, out_pc4, 32'h0050_0000 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (out_valid4 !== 1'b0 || occupancy4 !== 3'd0) begin
            errors++;
            $display("FAIL d4_empty valid=%b occ=%0d want 0 0", out_valid4, occupancy4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_depth4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
